esm_dwell_program_sequencer: RTL and testbench

Steps through a programmable list of dwell instructions and issues dwell requests, one at a time, to esm_dwell_controller's dwell-start interface. Each instruction names a dwell table entry and a repeat count. The block waits for dwell completion before issuing the next request. It sits between esm_config (instruction writes, enable) and esm_dwell_controller (dwell execution).

---
 rtl/esm_pkg.sv | 25 ++
 rtl/esm_dwell_program_mem.sv | 30 +++
 rtl/esm_dwell_program_sequencer.sv | 161 ++++++++++++++++
 tb/tb_esm_dwell_program_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// Shared types for the ESM dwell program sequencer: instruction word layout,
// program depth and the sequencer state encoding.
package esm_pkg;

    localparam int esm_num_dwell_instructions = 32;
    localparam int esm_dwell_index_width      = 5;
    localparam int esm_repeat_width           = 8;

    typedef struct packed {
        logic [esm_dwell_index_width-1:0] dwell_index;
        logic [esm_repeat_width-1:0]      repeat_count;
        logic                             last;
    } esm_dwell_instruction_t;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_FETCH     = 3'd1,
        SEQ_DECODE    = 3'd2,
        SEQ_ISSUE     = 3'd3,
        SEQ_WAIT_DONE = 3'd4,
        SEQ_ADVANCE   = 3'd5,
        SEQ_STOP      = 3'd6
    } esm_seq_state_e;

endpackage

// File: rtl/esm_dwell_program_mem.sv
// Program store: one write port, one registered read port. A read of an address
// being written in the same cycle returns the previous contents.
module esm_dwell_program_mem
    import esm_pkg::*;
#(
    parameter int DEPTH = esm_num_dwell_instructions,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   wr_en_i,
    input  logic [AW-1:0]          wr_addr_i,
    input  esm_dwell_instruction_t wr_data_i,
    input  logic [AW-1:0]          rd_addr_i,
    output esm_dwell_instruction_t rd_data_o
);

    esm_dwell_instruction_t mem_q [DEPTH];
    esm_dwell_instruction_t rd_data_q;

    // Contents are deliberately not reset so the program survives a reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/esm_dwell_program_sequencer.sv
// Walks the dwell program and issues one dwell request at a time to the dwell
// controller, waiting for each dwell to finish before issuing the next.
module esm_dwell_program_sequencer
    import esm_pkg::*;
#(
    parameter int NUM_INSTRUCTIONS  = esm_num_dwell_instructions,
    parameter int DWELL_INDEX_WIDTH = esm_dwell_index_width,
    parameter int REPEAT_WIDTH      = esm_repeat_width,
    parameter int SEQ_WIDTH         = 16,
    localparam int AW               = $clog2(NUM_INSTRUCTIONS)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         instr_wr_valid_i,
    input  logic [AW-1:0]                instr_wr_addr_i,
    input  esm_dwell_instruction_t       instr_wr_data_i,
    input  logic                         program_enable_i,
    input  logic                         loop_enable_i,
    // Request handshake: valid rises in ISSUE and holds with a stable index until
    // ready; transfer happens on valid & ready. Only reset may drop valid early.
    output logic                         dwell_req_valid_o,
    input  logic                         dwell_req_ready_i,
    output logic [DWELL_INDEX_WIDTH-1:0] dwell_req_index_o,
    output logic [SEQ_WIDTH-1:0]         dwell_req_seq_o,
    input  logic                         dwell_done_i,
    output logic                         program_active_o,
    output logic                         program_done_o,
    output logic [AW-1:0]                current_instr_o,
    output esm_seq_state_e               state_o
);

    localparam logic [AW-1:0] LAST_PTR = AW'(NUM_INSTRUCTIONS - 1);

    esm_seq_state_e               state_q, state_d;
    logic [AW-1:0]                ptr_q, ptr_d;
    logic [REPEAT_WIDTH-1:0]      rep_q, rep_d;
    logic [SEQ_WIDTH-1:0]         seq_q, seq_d;
    logic [DWELL_INDEX_WIDTH-1:0] idx_q, idx_d;
    logic                         last_q, last_d;
    logic                         pass_issued_q, pass_issued_d;
    logic                         en_q;
    logic                         at_end;
    esm_dwell_instruction_t       rd_data;

    esm_dwell_program_mem #(
        .DEPTH (NUM_INSTRUCTIONS)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (instr_wr_valid_i),
        .wr_addr_i (instr_wr_addr_i),
        .wr_data_i (instr_wr_data_i),
        .rd_addr_i (ptr_q),
        .rd_data_o (rd_data)
    );

    assign at_end = last_q || (ptr_q == LAST_PTR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= SEQ_IDLE;
            ptr_q         <= '0;
            rep_q         <= '0;
            seq_q         <= '0;
            idx_q         <= '0;
            last_q        <= 1'b0;
            pass_issued_q <= 1'b0;
            en_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            rep_q         <= rep_d;
            seq_q         <= seq_d;
            idx_q         <= idx_d;
            last_q        <= last_d;
            pass_issued_q <= pass_issued_d;
            en_q          <= program_enable_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        rep_d         = rep_q;
        seq_d         = seq_q;
        idx_d         = idx_q;
        last_d        = last_q;
        pass_issued_d = pass_issued_q;
        case (state_q)
            SEQ_IDLE: begin
                // Start only on a fresh rising edge of the enable level.
                if (program_enable_i && !en_q) begin
                    state_d       = SEQ_FETCH;
                    ptr_d         = '0;
                    pass_issued_d = 1'b0;
                end
            end
            SEQ_FETCH: begin
                state_d = program_enable_i ? SEQ_DECODE : SEQ_STOP;
            end
            SEQ_DECODE: begin
                if (!program_enable_i) begin
                    state_d = SEQ_STOP;
                end else begin
                    idx_d  = rd_data.dwell_index;
                    last_d = rd_data.last;
                    if (rd_data.repeat_count == '0) begin
                        state_d = SEQ_ADVANCE;
                    end else begin
                        rep_d   = rd_data.repeat_count;
                        state_d = SEQ_ISSUE;
                    end
                end
            end
            SEQ_ISSUE: begin
                if (dwell_req_ready_i) begin
                    seq_d         = seq_q + 1'b1;
                    pass_issued_d = 1'b1;
                    state_d       = SEQ_WAIT_DONE;
                end
            end
            SEQ_WAIT_DONE: begin
                if (dwell_done_i) begin
                    rep_d   = rep_q - 1'b1;
                    state_d = ((rep_d != '0) && program_enable_i) ? SEQ_ISSUE : SEQ_ADVANCE;
                end
            end
            SEQ_ADVANCE: begin
                if (!program_enable_i) begin
                    state_d = SEQ_STOP;
                end else if (at_end) begin
                    // A wrap after a pass with no dwells would spin forever.
                    if (!loop_enable_i || !pass_issued_q) begin
                        state_d = SEQ_STOP;
                    end else begin
                        ptr_d         = '0;
                        pass_issued_d = 1'b0;
                        state_d       = SEQ_FETCH;
                    end
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = SEQ_FETCH;
                end
            end
            SEQ_STOP: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    assign dwell_req_valid_o = (state_q == SEQ_ISSUE);
    assign dwell_req_index_o = idx_q;
    assign dwell_req_seq_o   = seq_q;
    assign program_active_o  = (state_q != SEQ_IDLE);
    assign program_done_o    = (state_q == SEQ_STOP);
    assign current_instr_o   = ptr_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_esm_dwell_program_sequencer.sv
// Directed bench for the dwell program sequencer: expected requests are queued
// by the stimulus and checked by an independent monitor on each handshake.
module tb_esm_dwell_program_sequencer;
    import esm_pkg::*;

    localparam int AW = 5;
    localparam int SW = 16;
    localparam int XW = 5 + SW;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   instr_wr_valid_i = 1'b0;
    logic [AW-1:0]          instr_wr_addr_i = '0;
    esm_dwell_instruction_t instr_wr_data_i = '0;
    logic                   program_enable_i = 1'b0;
    logic                   loop_enable_i = 1'b0;
    logic                   dwell_req_valid_o;
    logic                   dwell_req_ready_i = 1'b1;
    logic [4:0]             dwell_req_index_o;
    logic [SW-1:0]          dwell_req_seq_o;
    logic                   dwell_done_i;
    logic                   program_active_o;
    logic                   program_done_o;
    logic [AW-1:0]          current_instr_o;
    esm_seq_state_e         state_o;

    esm_dwell_program_sequencer dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .instr_wr_valid_i  (instr_wr_valid_i),
        .instr_wr_addr_i   (instr_wr_addr_i),
        .instr_wr_data_i   (instr_wr_data_i),
        .program_enable_i  (program_enable_i),
        .loop_enable_i     (loop_enable_i),
        .dwell_req_valid_o (dwell_req_valid_o),
        .dwell_req_ready_i (dwell_req_ready_i),
        .dwell_req_index_o (dwell_req_index_o),
        .dwell_req_seq_o   (dwell_req_seq_o),
        .dwell_done_i      (dwell_done_i),
        .program_active_o  (program_active_o),
        .program_done_o    (program_done_o),
        .current_instr_o   (current_instr_o),
        .state_o           (state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [XW-1:0] exp_q[$];
    int acc_cnt = 0;
    int done_cnt = 0;
    int done_delay = 20;
    int countdown = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [XW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && dwell_req_valid_o && dwell_req_ready_i) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_req: got idx %0d seq %0d, expected no request",
                             dwell_req_index_o, dwell_req_seq_o);
                end else begin
                    e = exp_q.pop_front();
                    check("req_index", 32'(dwell_req_index_o), 32'(e[XW-1:SW]));
                    check("req_seq", 32'(dwell_req_seq_o), 32'(e[SW-1:0]));
                end
            end
            if (!rst && program_done_o) done_cnt++;
        end
    end

    // ---------------- dwell controller model ----------------
    initial begin
        dwell_done_i = 1'b0;
        forever begin
            @(negedge clk);
            dwell_done_i = 1'b0;
            if (rst) begin
                countdown = 0;
            end else begin
                if (countdown > 0) begin
                    countdown--;
                    if (countdown == 0) dwell_done_i = 1'b1;
                end
                if (dwell_req_valid_o && dwell_req_ready_i) countdown = done_delay;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        program_enable_i = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic write_instr(input int addr, input int idx, input int rep, input logic last);
        instr_wr_valid_i = 1'b1;
        instr_wr_addr_i = AW'(addr);
        instr_wr_data_i.dwell_index = 5'(idx);
        instr_wr_data_i.repeat_count = 8'(rep);
        instr_wr_data_i.last = last;
        step(1);
        instr_wr_valid_i = 1'b0;
    endtask

    task automatic push_exp(input int idx, input int seq);
        exp_q.push_back({5'(idx), SW'(seq)});
    endtask

    task automatic wait_prog_done(input string name, input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            step(1);
            n++;
        end
        check(name, 32'(done_cnt != start), 32'd1);
    endtask

    task automatic wait_acc(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (acc_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        check(name, 32'(acc_cnt >= target), 32'd1);
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_valid"}, 32'(dwell_req_valid_o), 32'd0);
        check({pfx, "_active"}, 32'(program_active_o), 32'd0);
        check({pfx, "_done"}, 32'(program_done_o), 32'd0);
        check({pfx, "_seq"}, 32'(dwell_req_seq_o), 32'd0);
        check({pfx, "_index"}, 32'(dwell_req_index_o), 32'd0);
        check({pfx, "_instr"}, 32'(current_instr_o), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    // ---------------- directed tests ----------------
    initial begin
        int base_acc;
        int base_done;
        logic stable;

        do_reset();
        check_idle_outputs("reset");

        // Basic program, latency and single termination pulse.
        write_instr(0, 3, 2, 1'b0);
        write_instr(1, 7, 1, 1'b1);
        push_exp(3, 0);
        push_exp(3, 1);
        push_exp(7, 2);
        base_done = done_cnt;
        program_enable_i = 1'b1;
        step(2);
        check("latency_t2_valid", 32'(dwell_req_valid_o), 32'd0);
        step(1);
        check("latency_t3_valid", 32'(dwell_req_valid_o), 32'd1);
        check("latency_t3_index", 32'(dwell_req_index_o), 32'd3);
        wait_prog_done("basic_done_seen", 200);
        step(30);
        check("basic_done_once", 32'(done_cnt - base_done), 32'd1);
        check("basic_queue_empty", 32'(exp_q.size()), 32'd0);
        check("basic_seq_final", 32'(dwell_req_seq_o), 32'd3);
        check("basic_inactive", 32'(program_active_o), 32'd0);
        program_enable_i = 1'b0;
        step(2);

        // Looping for two passes, disabled during the sixth dwell.
        do_reset();
        loop_enable_i = 1'b1;
        for (int p = 0; p < 2; p++) begin
            push_exp(3, p * 3);
            push_exp(3, p * 3 + 1);
            push_exp(7, p * 3 + 2);
        end
        base_acc = acc_cnt;
        base_done = done_cnt;
        program_enable_i = 1'b1;
        wait_acc("loop_six_accepted", base_acc + 6, 400);
        step(5);
        program_enable_i = 1'b0;
        wait_prog_done("loop_done_seen", 100);
        step(40);
        check("loop_accept_count", 32'(acc_cnt - base_acc), 32'd6);
        check("loop_done_once", 32'(done_cnt - base_done), 32'd1);
        check("loop_queue_empty", 32'(exp_q.size()), 32'd0);

        // Ready held low: request must stay stable, then complete after disable.
        do_reset();
        loop_enable_i = 1'b0;
        dwell_req_ready_i = 1'b0;
        base_acc = acc_cnt;
        program_enable_i = 1'b1;
        step(3);
        check("stall_valid_up", 32'(dwell_req_valid_o), 32'd1);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (!(dwell_req_valid_o === 1'b1 && dwell_req_index_o === 5'd3)) stable = 1'b0;
            if (i == 10) program_enable_i = 1'b0;
            step(1);
        end
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_seq_held", 32'(dwell_req_seq_o), 32'd0);
        push_exp(3, 0);
        dwell_req_ready_i = 1'b1;
        wait_prog_done("stall_done_seen", 100);
        check("stall_accept_count", 32'(acc_cnt - base_acc), 32'd1);
        check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

        // All-skip program with looping: empty-pass guard must terminate it.
        do_reset();
        write_instr(0, 1, 0, 1'b0);
        write_instr(1, 2, 0, 1'b1);
        loop_enable_i = 1'b1;
        base_acc = acc_cnt;
        program_enable_i = 1'b1;
        wait_prog_done("empty_done_within_10", 10);
        check("empty_no_requests", 32'(acc_cnt - base_acc), 32'd0);
        program_enable_i = 1'b0;
        loop_enable_i = 1'b0;

        // Full 32-entry program without a last marker.
        do_reset();
        done_delay = 2;
        for (int i = 0; i < 32; i++) begin
            write_instr(i, i, 1, 1'b0);
            push_exp(i, i);
        end
        base_acc = acc_cnt;
        base_done = done_cnt;
        program_enable_i = 1'b1;
        wait_prog_done("full_done_seen", 1000);
        check("full_ptr_at_31", 32'(current_instr_o), 32'd31);
        step(20);
        check("full_accept_count", 32'(acc_cnt - base_acc), 32'd32);
        check("full_done_once", 32'(done_cnt - base_done), 32'd1);
        check("full_queue_empty", 32'(exp_q.size()), 32'd0);
        program_enable_i = 1'b0;

        // Reset during WAIT_DONE, then restart from retained memory.
        done_delay = 20;
        write_instr(0, 3, 2, 1'b0);
        write_instr(1, 7, 1, 1'b1);
        do_reset();
        base_acc = acc_cnt;
        push_exp(3, 0);
        program_enable_i = 1'b1;
        wait_acc("rst_first_accept", base_acc + 1, 20);
        step(5);
        check("rst_in_wait_done", 32'(state_o), 32'(SEQ_WAIT_DONE));
        rst = 1'b1;
        program_enable_i = 1'b0;
        step(1);
        check_idle_outputs("midrst");
        rst = 1'b0;
        step(2);
        push_exp(3, 0);
        push_exp(3, 1);
        push_exp(7, 2);
        program_enable_i = 1'b1;
        wait_prog_done("restart_done_seen", 200);
        check("restart_queue_empty", 32'(exp_q.size()), 32'd0);
        program_enable_i = 1'b0;
        step(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
